// File: rtl/llc_set_reader_pkg.sv
// Shared LLC cache types and constants used by the set reader and its per-way buffers.
package llc_set_reader_pkg;

    localparam int unsigned LLC_WAYS      = 8;
    localparam int unsigned LLC_NUM_PORTS = LLC_WAYS;
    localparam int unsigned LLC_WAY_BITS  = 3;
    localparam int unsigned LLC_SET_BITS  = 8;
    localparam int unsigned LLC_TAG_BITS  = 16;
    localparam int unsigned LINE_BITS     = 64;
    localparam int unsigned STATE_BITS    = 3;
    localparam int unsigned SHARERS_BITS  = 16;
    localparam int unsigned OWNER_BITS    = 4;

    typedef logic [LLC_SET_BITS-1:0] llc_set_t;
    typedef logic [LLC_WAY_BITS-1:0] llc_way_t;
    typedef logic [STATE_BITS-1:0]   llc_state_t;
    typedef logic                    hprot_t;
    typedef logic [LINE_BITS-1:0]    line_t;
    typedef logic [LLC_TAG_BITS-1:0] llc_tag_t;
    typedef logic [SHARERS_BITS-1:0] sharers_t;
    typedef logic [OWNER_BITS-1:0]   owner_t;

    localparam llc_state_t INVALID   = 3'd0;
    localparam llc_state_t VALID     = 3'd1;
    localparam llc_state_t SHARED    = 3'd2;
    localparam llc_state_t EXCLUSIVE = 3'd3;
    localparam llc_state_t MODIFIED  = 3'd4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } llc_set_reader_state_t;

endpackage

// File: rtl/llc_way_buf.sv
// One way of the set buffer: registers the memory read data, merged with
// write-back snoops (flush beats write, write beats memory data).
module llc_way_buf
    import llc_set_reader_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       wr_hit,
    input  logic       flush,
    input  logic       mem_dirty_bit,
    input  llc_state_t mem_state,
    input  hprot_t     mem_hprot,
    input  line_t      mem_line,
    input  llc_tag_t   mem_tag,
    input  sharers_t   mem_sharers,
    input  owner_t     mem_owner,
    input  logic       wr_dirty_bit,
    input  llc_state_t wr_state,
    input  hprot_t     wr_hprot,
    input  line_t      wr_line,
    input  llc_tag_t   wr_tag,
    input  sharers_t   wr_sharers,
    input  owner_t     wr_owner,
    output logic       dirty_bit,
    output llc_state_t state,
    output hprot_t     hprot,
    output line_t      line,
    output llc_tag_t   tag,
    output sharers_t   sharers,
    output owner_t     owner
);

    logic       dirty_bit_d;
    llc_state_t state_d;
    hprot_t     hprot_d;
    line_t      line_d;
    llc_tag_t   tag_d;
    sharers_t   sharers_d;
    owner_t     owner_d;

    // Later assignments win: memory < write-back write < flush.
    always_comb begin
        dirty_bit_d = dirty_bit;
        state_d     = state;
        hprot_d     = hprot;
        line_d      = line;
        tag_d       = tag;
        sharers_d   = sharers;
        owner_d     = owner;
        if (load) begin
            dirty_bit_d = mem_dirty_bit;
            state_d     = mem_state;
            hprot_d     = mem_hprot;
            line_d      = mem_line;
            tag_d       = mem_tag;
            sharers_d   = mem_sharers;
            owner_d     = mem_owner;
        end
        if (wr_hit) begin
            dirty_bit_d = wr_dirty_bit;
            state_d     = wr_state;
            hprot_d     = wr_hprot;
            line_d      = wr_line;
            tag_d       = wr_tag;
            sharers_d   = wr_sharers;
            owner_d     = wr_owner;
        end
        if (flush) begin
            state_d     = INVALID;
            dirty_bit_d = 1'b0;
            sharers_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dirty_bit <= 1'b0;
            state     <= INVALID;
            hprot     <= '0;
            line      <= '0;
            tag       <= '0;
            sharers   <= '0;
            owner     <= '0;
        end else begin
            dirty_bit <= dirty_bit_d;
            state     <= state_d;
            hprot     <= hprot_d;
            line      <= line_d;
            tag       <= tag_d;
            sharers   <= sharers_d;
            owner     <= owner_d;
        end
    end

endmodule

// File: rtl/llc_set_reader.sv
// Reads every way of one LLC set into per-way buffers for the process stage,
// snooping the write-back port so held buffers stay coherent with memory.
module llc_set_reader
    import llc_set_reader_pkg::*;
#(
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rd_req_valid,
    output logic                     rd_req_ready,
    input  llc_set_t                 rd_req_set,
    output logic                     rd_mem_en,
    output llc_set_t                 rd_mem_set,
    input  logic                     rd_dirty_bits [LLC_WAYS],
    input  llc_state_t               rd_states     [LLC_WAYS],
    input  hprot_t                   rd_hprots     [LLC_WAYS],
    input  line_t                    rd_lines      [LLC_WAYS],
    input  llc_tag_t                 rd_tags       [LLC_WAYS],
    input  sharers_t                 rd_sharers    [LLC_WAYS],
    input  owner_t                   rd_owners     [LLC_WAYS],
    input  llc_way_t                 rd_evict_way,
    input  logic                     wr_en,
    input  logic                     wr_en_evict_way,
    input  logic [LLC_NUM_PORTS-1:0] wr_rst_flush,
    input  llc_set_t                 wr_set,
    input  llc_way_t                 wr_way,
    input  logic                     wr_data_dirty_bit,
    input  llc_state_t               wr_data_state,
    input  hprot_t                   wr_data_hprot,
    input  line_t                    wr_data_line,
    input  llc_tag_t                 wr_data_tag,
    input  sharers_t                 wr_data_sharers,
    input  owner_t                   wr_data_owner,
    input  llc_way_t                 wr_data_evict_way,
    output logic                     bufs_valid,
    output llc_set_t                 bufs_set,
    input  logic                     bufs_done,
    output logic                     dirty_bits_buf [LLC_WAYS],
    output llc_state_t               states_buf     [LLC_WAYS],
    output hprot_t                   hprots_buf     [LLC_WAYS],
    output line_t                    lines_buf      [LLC_WAYS],
    output llc_tag_t                 tags_buf       [LLC_WAYS],
    output sharers_t                 sharers_buf    [LLC_WAYS],
    output owner_t                   owners_buf     [LLC_WAYS],
    output llc_way_t                 evict_way_buf
);

    localparam int unsigned CNT_W = 2;

    llc_set_reader_state_t state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    llc_set_t              cur_set_q, cur_set_d;
    logic                  latch;
    logic                  snoop;
    llc_way_t              evict_d;
    logic [LLC_WAYS-1:0]   way_hit;
    logic [LLC_WAYS-1:0]   way_flush;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            cur_set_q    <= '0;
            rd_req_ready <= 1'b1;
            bufs_valid   <= 1'b0;
            bufs_set     <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            cur_set_q    <= cur_set_d;
            rd_req_ready <= (state_d == IDLE);
            bufs_valid   <= (state_d == HOLD);
            if (latch) begin
                bufs_set <= cur_set_q;
            end
        end
    end

    // Memory address/enable go out in the accept cycle so data lands RD_LATENCY later.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cur_set_d  = cur_set_q;
        rd_mem_en  = 1'b0;
        rd_mem_set = cur_set_q;
        latch      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (rd_req_valid) begin
                    rd_mem_en  = 1'b1;
                    rd_mem_set = rd_req_set;
                    cur_set_d  = rd_req_set;
                    cnt_d      = CNT_W'(RD_LATENCY - 1);
                    state_d    = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    latch   = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (bufs_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Earlier WAIT cycles need no snoop: memory is write-first.
    assign snoop = (latch || (state_q == HOLD)) && (wr_set == cur_set_q);

    always_comb begin
        evict_d = evict_way_buf;
        if (latch) begin
            evict_d = rd_evict_way;
        end
        if (snoop && wr_en_evict_way) begin
            evict_d = wr_data_evict_way;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            evict_way_buf <= '0;
        end else begin
            evict_way_buf <= evict_d;
        end
    end

    for (genvar w = 0; w < LLC_WAYS; w++) begin : g_way
        assign way_hit[w]   = snoop && wr_en && (wr_way == LLC_WAY_BITS'(w));
        assign way_flush[w] = snoop && wr_rst_flush[w];

        llc_way_buf u_way_buf (
            .clk           (clk),
            .rst           (rst),
            .load          (latch),
            .wr_hit        (way_hit[w]),
            .flush         (way_flush[w]),
            .mem_dirty_bit (rd_dirty_bits[w]),
            .mem_state     (rd_states[w]),
            .mem_hprot     (rd_hprots[w]),
            .mem_line      (rd_lines[w]),
            .mem_tag       (rd_tags[w]),
            .mem_sharers   (rd_sharers[w]),
            .mem_owner     (rd_owners[w]),
            .wr_dirty_bit  (wr_data_dirty_bit),
            .wr_state      (wr_data_state),
            .wr_hprot      (wr_data_hprot),
            .wr_line       (wr_data_line),
            .wr_tag        (wr_data_tag),
            .wr_sharers    (wr_data_sharers),
            .wr_owner      (wr_data_owner),
            .dirty_bit     (dirty_bits_buf[w]),
            .state         (states_buf[w]),
            .hprot         (hprots_buf[w]),
            .line          (lines_buf[w]),
            .tag           (tags_buf[w]),
            .sharers       (sharers_buf[w]),
            .owner         (owners_buf[w])
        );
    end

endmodule

// File: tb/tb_llc_set_reader.sv
// Directed bench for llc_set_reader: latch-cycle snoop table plus hand sequences.
module tb_llc_set_reader;
    import llc_set_reader_pkg::*;

    logic clk, rst;
    logic req_valid1, req_valid3, done1, done3;
    llc_set_t req_set;
    logic ready1, ready3, mem_en1, mem_en3;
    llc_set_t mem_set1, mem_set3;

    logic       rd_dirty_bits [LLC_WAYS];
    llc_state_t rd_states     [LLC_WAYS];
    hprot_t     rd_hprots     [LLC_WAYS];
    line_t      rd_lines      [LLC_WAYS];
    llc_tag_t   rd_tags       [LLC_WAYS];
    sharers_t   rd_sharers    [LLC_WAYS];
    owner_t     rd_owners     [LLC_WAYS];
    llc_way_t   rd_evict_way;

    logic wr_en, wr_en_evict_way;
    logic [LLC_NUM_PORTS-1:0] wr_rst_flush;
    llc_set_t wr_set;
    llc_way_t wr_way;
    logic wr_data_dirty_bit;
    llc_state_t wr_data_state;
    hprot_t wr_data_hprot;
    line_t wr_data_line;
    llc_tag_t wr_data_tag;
    sharers_t wr_data_sharers;
    owner_t wr_data_owner;
    llc_way_t wr_data_evict_way;

    logic bufs_valid1, bufs_valid3;
    llc_set_t bufs_set1, bufs_set3;
    logic       dirty1 [LLC_WAYS], dirty3 [LLC_WAYS];
    llc_state_t states1 [LLC_WAYS], states3 [LLC_WAYS];
    hprot_t     hprots1 [LLC_WAYS], hprots3 [LLC_WAYS];
    line_t      lines1 [LLC_WAYS], lines3 [LLC_WAYS];
    llc_tag_t   tags1 [LLC_WAYS], tags3 [LLC_WAYS];
    sharers_t   sharers1 [LLC_WAYS], sharers3 [LLC_WAYS];
    owner_t     owners1 [LLC_WAYS], owners3 [LLC_WAYS];
    llc_way_t   evict1, evict3;

    llc_set_reader #(.RD_LATENCY(1)) u_dut1 (
        .clk(clk), .rst(rst), .rd_req_valid(req_valid1), .rd_req_ready(ready1),
        .rd_req_set(req_set), .rd_mem_en(mem_en1), .rd_mem_set(mem_set1),
        .rd_dirty_bits(rd_dirty_bits), .rd_states(rd_states), .rd_hprots(rd_hprots),
        .rd_lines(rd_lines), .rd_tags(rd_tags), .rd_sharers(rd_sharers), .rd_owners(rd_owners),
        .rd_evict_way(rd_evict_way), .wr_en(wr_en), .wr_en_evict_way(wr_en_evict_way),
        .wr_rst_flush(wr_rst_flush), .wr_set(wr_set), .wr_way(wr_way),
        .wr_data_dirty_bit(wr_data_dirty_bit), .wr_data_state(wr_data_state),
        .wr_data_hprot(wr_data_hprot), .wr_data_line(wr_data_line), .wr_data_tag(wr_data_tag),
        .wr_data_sharers(wr_data_sharers), .wr_data_owner(wr_data_owner),
        .wr_data_evict_way(wr_data_evict_way), .bufs_valid(bufs_valid1), .bufs_set(bufs_set1),
        .bufs_done(done1), .dirty_bits_buf(dirty1), .states_buf(states1), .hprots_buf(hprots1),
        .lines_buf(lines1), .tags_buf(tags1), .sharers_buf(sharers1), .owners_buf(owners1),
        .evict_way_buf(evict1)
    );

    llc_set_reader #(.RD_LATENCY(3)) u_dut3 (
        .clk(clk), .rst(rst), .rd_req_valid(req_valid3), .rd_req_ready(ready3),
        .rd_req_set(req_set), .rd_mem_en(mem_en3), .rd_mem_set(mem_set3),
        .rd_dirty_bits(rd_dirty_bits), .rd_states(rd_states), .rd_hprots(rd_hprots),
        .rd_lines(rd_lines), .rd_tags(rd_tags), .rd_sharers(rd_sharers), .rd_owners(rd_owners),
        .rd_evict_way(rd_evict_way), .wr_en(wr_en), .wr_en_evict_way(wr_en_evict_way),
        .wr_rst_flush(wr_rst_flush), .wr_set(wr_set), .wr_way(wr_way),
        .wr_data_dirty_bit(wr_data_dirty_bit), .wr_data_state(wr_data_state),
        .wr_data_hprot(wr_data_hprot), .wr_data_line(wr_data_line), .wr_data_tag(wr_data_tag),
        .wr_data_sharers(wr_data_sharers), .wr_data_owner(wr_data_owner),
        .wr_data_evict_way(wr_data_evict_way), .bufs_valid(bufs_valid3), .bufs_set(bufs_set3),
        .bufs_done(done3), .dirty_bits_buf(dirty3), .states_buf(states3), .hprots_buf(hprots3),
        .lines_buf(lines3), .tags_buf(tags3), .sharers_buf(sharers3), .owners_buf(owners3),
        .evict_way_buf(evict3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_writes();
        wr_en           = 1'b0;
        wr_en_evict_way = 1'b0;
        wr_rst_flush    = '0;
        wr_set          = 8'd0;
    endtask

    task automatic release1();
        done1 = 1'b1;
        tick();
        done1 = 1'b0;
    endtask

    // Accept a set on the RD_LATENCY=1 instance and step into the latch cycle.
    task automatic accept1(input llc_set_t s);
        req_valid1 = 1'b1;
        req_set    = s;
        tick();
        req_valid1 = 1'b0;
    endtask

    // Latch-cycle snoop vectors, cur_set=5, wr_way=2, wr data SHARED/0xDEAD/dirty 0, evict 7.
    typedef struct {
        logic        wen;
        logic [7:0]  flush;
        logic        ev_we;
        logic [7:0]  wset;
        llc_state_t  e_st2;
        logic [63:0] e_line2;
        llc_state_t  e_st1;
        logic        e_dirty2;
        llc_way_t    e_evict;
    } vec_t;

    vec_t vecs [7];

    initial begin
        vecs[0] = '{1'b0, 8'h00, 1'b0, 8'd5, VALID,   64'h1002, VALID, 1'b1, 3'd3};
        vecs[1] = '{1'b1, 8'h00, 1'b0, 8'd5, SHARED,  64'hDEAD, VALID, 1'b0, 3'd3};
        vecs[2] = '{1'b1, 8'h00, 1'b0, 8'd6, VALID,   64'h1002, VALID, 1'b1, 3'd3};
        vecs[3] = '{1'b1, 8'h04, 1'b0, 8'd5, INVALID, 64'hDEAD, VALID, 1'b0, 3'd3};
        vecs[4] = '{1'b0, 8'h04, 1'b0, 8'd5, INVALID, 64'h1002, VALID, 1'b0, 3'd3};
        vecs[5] = '{1'b0, 8'h00, 1'b1, 8'd5, VALID,   64'h1002, VALID, 1'b1, 3'd7};
        vecs[6] = '{1'b0, 8'h00, 1'b1, 8'd6, VALID,   64'h1002, VALID, 1'b1, 3'd3};

        for (int w = 0; w < int'(LLC_WAYS); w++) begin
            rd_dirty_bits[w] = 1'b1;
            rd_states[w]     = VALID;
            rd_hprots[w]     = 1'b1;
            rd_lines[w]      = 64'h1000 + 64'(w);
            rd_tags[w]       = 16'h0010 + 16'(w);
            rd_sharers[w]    = 16'h00F0 | 16'(w);
            rd_owners[w]     = 4'(w);
        end
        rd_tags[3]   = 16'h001A;
        rd_evict_way = 3'd3;

        wr_way            = 3'd2;
        wr_data_dirty_bit = 1'b0;
        wr_data_state     = SHARED;
        wr_data_hprot     = 1'b0;
        wr_data_line      = 64'hDEAD;
        wr_data_tag       = 16'h0055;
        wr_data_sharers   = '0;
        wr_data_owner     = '0;
        wr_data_evict_way = 3'd7;
        clear_writes();
        req_valid1 = 1'b0;
        req_valid3 = 1'b0;
        done1      = 1'b0;
        done3      = 1'b0;
        req_set    = 8'd0;

        // Reset values
        rst = 1'b0;
        tick();
        tick();
        chk("rst_ready", 64'(ready1), 64'd1);
        chk("rst_valid", 64'(bufs_valid1), 64'd0);
        chk("rst_mem_en", 64'(mem_en1), 64'd0);
        chk("rst_tag3", 64'(tags1[3]), 64'd0);
        chk("rst_bufs_set", 64'(bufs_set1), 64'd0);
        chk("rst_evict", 64'(evict1), 64'd0);
        rst = 1'b1;
        tick();

        // Basic read, RD_LATENCY=1
        req_valid1 = 1'b1;
        req_set    = 8'd5;
        #1;
        chk("basic_mem_en", 64'(mem_en1), 64'd1);
        chk("basic_mem_set", 64'(mem_set1), 64'd5);
        tick();
        req_valid1 = 1'b0;
        chk("basic_wait_ready", 64'(ready1), 64'd0);
        chk("basic_wait_valid", 64'(bufs_valid1), 64'd0);
        chk("basic_wait_mem_en", 64'(mem_en1), 64'd0);
        tick();
        chk("basic_valid", 64'(bufs_valid1), 64'd1);
        chk("basic_tag3", 64'(tags1[3]), 64'h1A);
        chk("basic_bufs_set", 64'(bufs_set1), 64'd5);
        chk("basic_hold_ready", 64'(ready1), 64'd0);
        chk("basic_evict", 64'(evict1), 64'd3);
        done1 = 1'b1;
        #1;
        chk("basic_done_ready", 64'(ready1), 64'd0);
        tick();
        done1 = 1'b0;
        chk("basic_rel_valid", 64'(bufs_valid1), 64'd0);
        chk("basic_rel_ready", 64'(ready1), 64'd1);

        // Latch-cycle snoop table
        for (int i = 0; i < 7; i++) begin
            accept1(8'd5);
            wr_en           = vecs[i].wen;
            wr_rst_flush    = vecs[i].flush;
            wr_en_evict_way = vecs[i].ev_we;
            wr_set          = vecs[i].wset;
            tick();
            clear_writes();
            chk($sformatf("vec%0d_valid", i), 64'(bufs_valid1), 64'd1);
            chk($sformatf("vec%0d_st2", i), 64'(states1[2]), 64'(vecs[i].e_st2));
            chk($sformatf("vec%0d_line2", i), 64'(lines1[2]), vecs[i].e_line2);
            chk($sformatf("vec%0d_st1", i), 64'(states1[1]), 64'(vecs[i].e_st1));
            chk($sformatf("vec%0d_dirty2", i), 64'(dirty1[2]), 64'(vecs[i].e_dirty2));
            chk($sformatf("vec%0d_evict", i), 64'(evict1), 64'(vecs[i].e_evict));
            release1();
        end

        // HOLD snoop: flush to another set, then to the held set, then eviction pointer
        accept1(8'd5);
        tick();
        wr_rst_flush = '1;
        wr_set       = 8'd6;
        tick();
        chk("hold_other_st0", 64'(states1[0]), 64'(VALID));
        chk("hold_other_sh5", 64'(sharers1[5]), 64'h00F5);
        wr_set = 8'd5;
        tick();
        clear_writes();
        for (int w = 0; w < int'(LLC_WAYS); w++) begin
            chk($sformatf("hold_flush_w%0d", w),
                {40'd0, 5'(states1[w]), 3'd0, dirty1[w], 15'd0, sharers1[w]},
                {40'd0, 5'(INVALID), 3'd0, 1'b0, 15'd0, 16'd0});
        end
        chk("hold_flush_tag3", 64'(tags1[3]), 64'h1A);
        wr_en_evict_way = 1'b1;
        wr_set          = 8'd5;
        tick();
        clear_writes();
        chk("hold_evict", 64'(evict1), 64'd7);
        chk("hold_still_valid", 64'(bufs_valid1), 64'd1);
        release1();

        // RD_LATENCY=3: valid exactly 4 cycles after acceptance, early snoop ignored
        req_valid3 = 1'b1;
        req_set    = 8'd5;
        #1;
        chk("lat3_mem_en", 64'(mem_en3), 64'd1);
        tick();
        req_valid3   = 1'b0;
        wr_rst_flush = '1;
        wr_set       = 8'd5;
        tick();
        clear_writes();
        chk("lat3_c1_valid", 64'(bufs_valid3), 64'd0);
        tick();
        chk("lat3_c2_valid", 64'(bufs_valid3), 64'd0);
        tick();
        chk("lat3_c3_valid", 64'(bufs_valid3), 64'd1);
        chk("lat3_st0", 64'(states3[0]), 64'(VALID));
        chk("lat3_dirty0", 64'(dirty3[0]), 64'd1);
        chk("lat3_tag3", 64'(tags3[3]), 64'h1A);
        done3 = 1'b1;
        tick();
        done3 = 1'b0;
        chk("lat3_rel_ready", 64'(ready3), 64'd1);

        // Reset mid-HOLD, then a normal read
        accept1(8'd5);
        tick();
        chk("rsthold_valid_pre", 64'(bufs_valid1), 64'd1);
        rst = 1'b0;
        #1;
        chk("rsthold_valid", 64'(bufs_valid1), 64'd0);
        chk("rsthold_ready", 64'(ready1), 64'd1);
        chk("rsthold_tag3", 64'(tags1[3]), 64'd0);
        chk("rsthold_bufs_set", 64'(bufs_set1), 64'd0);
        rst = 1'b1;
        tick();
        req_valid1 = 1'b1;
        req_set    = 8'd9;
        #1;
        chk("post_rst_mem_en", 64'(mem_en1), 64'd1);
        tick();
        req_valid1 = 1'b0;
        tick();
        chk("post_rst_valid", 64'(bufs_valid1), 64'd1);
        chk("post_rst_set", 64'(bufs_set1), 64'd9);
        release1();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
